// File: rtl/sort_pkg.sv
// Shared types and elaboration-time helpers for the pipelined bitonic sorter.
package sort_pkg;

  typedef enum logic {
    DIR_ASC  = 1'b0,
    DIR_DESC = 1'b1
  } dir_e;

  // Control part of a stage record. The data part depends on N and W, so the
  // top wraps this together with its key bus into the full stage record.
  typedef struct packed {
    logic valid;
    logic desc;
  } stage_tag_t;

  // Number of compare-exchange layers in a bitonic network of n elements:
  // log2(n) * (log2(n) + 1) / 2.
  function automatic int num_stages(input int n);
    int l = 0;
    for (int t = 1; t < n; t = t * 2) l++;
    return l * (l + 1) / 2;
  endfunction

  // Base direction of the pair anchored at index i in the merge of block size k,
  // before the per-vector desc bit is applied.
  function automatic dir_e pair_dir(input int i, input int k);
    return ((i & k) == 0) ? DIR_ASC : DIR_DESC;
  endfunction

endpackage

// File: rtl/sort_stage.sv
// One combinational compare-exchange layer of the bitonic network (block size K,
// partner distance J). Purely combinational; the stage register lives in the top.
module sort_stage
  import sort_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 4,
  parameter int K = 2,
  parameter int J = 1
) (
  input  logic           desc,
  input  logic [N*W-1:0] keys,
  output logic [N*W-1:0] result
);

  // Every index belongs to exactly one pair, so each result slice has one driver.
  for (genvar i = 0; i < N; i++) begin : g_pair
    if ((i ^ J) > i) begin : g_cx
      localparam int P = i ^ J;
      localparam bit BASE_DESC = (pair_dir(i, K) == DIR_DESC);

      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         pair_desc;
      logic         swap;

      assign a         = keys[i*W +: W];
      assign b         = keys[P*W +: W];
      assign pair_desc = BASE_DESC ^ desc;
      // Strict compares: equal keys stay where they are.
      assign swap      = pair_desc ? (a < b) : (a > b);

      assign result[i*W +: W] = swap ? b : a;
      assign result[P*W +: W] = swap ? a : b;
    end
  end

endmodule

// File: rtl/sort_net_pipe.sv
// Fully pipelined bitonic sorting network: one N-key vector per cycle in,
// sorted (ascending or descending per vector) out STAGES cycles later.
// A single global enable stalls the whole pipe, bubbles included.
module sort_net_pipe
  import sort_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rstN,
  input  logic           inValid,
  output logic           inReady,
  input  logic [N*W-1:0] inData,
  input  logic           inDesc,
  output logic           outValid,
  input  logic           outReady,
  output logic [N*W-1:0] outData,
  output logic           outDesc
);

  localparam int LOG2N  = $clog2(N);
  localparam int STAGES = num_stages(N);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("sort_net_pipe: N must be a power of two and at least 2");
  end
  if (W < 1) begin : g_bad_w
    $error("sort_net_pipe: W must be at least 1");
  end

  typedef struct packed {
    stage_tag_t     tag;
    logic [N*W-1:0] data;
  } stage_t;

  stage_t         st_q     [STAGES];
  logic [N*W-1:0] lay_keys [STAGES];
  logic [N*W-1:0] lay_res  [STAGES];
  stage_tag_t     lay_tag  [STAGES];
  logic           en;

  // Stage numbering: merges k = 2..N in order, within each k partner
  // distance j = k/2 down to 1.
  for (genvar kk = 1; kk <= LOG2N; kk++) begin : g_k
    for (genvar jj = 0; jj < kk; jj++) begin : g_j
      localparam int S = kk * (kk - 1) / 2 + jj;
      localparam int K = 1 << kk;
      localparam int J = 1 << (kk - 1 - jj);

      if (S == 0) begin : g_first
        assign lay_keys[S] = inData;
        assign lay_tag[S]  = '{valid: inValid, desc: inDesc};
      end else begin : g_next
        assign lay_keys[S] = st_q[S-1].data;
        assign lay_tag[S]  = st_q[S-1].tag;
      end

      sort_stage #(
        .W(W),
        .N(N),
        .K(K),
        .J(J)
      ) u_stage (
        .desc  (lay_tag[S].desc),
        .keys  (lay_keys[S]),
        .result(lay_res[S])
      );
    end
  end

  // Pipe advances unless the output holds a vector nobody is taking; inReady is
  // therefore combinational from outValid and outReady.
  always_comb begin
    en      = !outValid || outReady;
    inReady = en;
  end

  // Stage registers: capture each layer's result, or hold everything on stall.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int s = 0; s < STAGES; s++) st_q[s] <= '0;
    end else if (en) begin
      for (int s = 0; s < STAGES; s++) st_q[s] <= '{tag: lay_tag[s], data: lay_res[s]};
    end
  end

  // Outputs come straight from the last stage register.
  always_comb begin
    outValid = st_q[STAGES-1].tag.valid;
    outDesc  = st_q[STAGES-1].tag.desc;
    outData  = st_q[STAGES-1].data;
  end

endmodule

// File: tb/tb_sort_net_pipe.sv
// Directed bench for sort_net_pipe: an N=4 and an N=8 instance (W=4) share
// clock and reset. Latency counts clock edges starting with the accepting edge.
module tb_sort_net_pipe;

  logic        clk;
  logic        rstN;

  logic        iv4, ir4, idesc4, ov4, or4, odesc4;
  logic [15:0] id4, od4;
  logic        iv8, ir8, idesc8, ov8, or8, odesc8;
  logic [31:0] id8, od8;

  logic        sel8;
  logic        o_valid, o_desc;
  logic [31:0] o_data;

  int errors;
  int checks;

  typedef struct {
    int          n;
    logic [31:0] data;
    logic        desc;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  sort_net_pipe #(.W(4), .N(4)) dut4 (
    .clk(clk), .rstN(rstN),
    .inValid(iv4), .inReady(ir4), .inData(id4), .inDesc(idesc4),
    .outValid(ov4), .outReady(or4), .outData(od4), .outDesc(odesc4)
  );

  sort_net_pipe #(.W(4), .N(8)) dut8 (
    .clk(clk), .rstN(rstN),
    .inValid(iv8), .inReady(ir8), .inData(id8), .inDesc(idesc8),
    .outValid(ov8), .outReady(or8), .outData(od8), .outDesc(odesc8)
  );

  assign o_valid = sel8 ? ov8 : ov4;
  assign o_desc  = sel8 ? odesc8 : odesc4;
  assign o_data  = sel8 ? od8 : {16'h0, od4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk4(input logic [3:0] e0, e1, e2, e3);
    return {16'h0, e3, e2, e1, e0};
  endfunction

  function automatic logic [31:0] pk8(input logic [3:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  // Reference: plain bubble sort of n 4-bit keys.
  function automatic logic [31:0] ref_sort(input logic [31:0] d, input int n, input logic desc);
    logic [3:0]  e[8];
    logic [3:0]  t;
    logic [31:0] r;
    for (int i = 0; i < 8; i++) e[i] = (i < n) ? d[i*4 +: 4] : 4'h0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n - 1 - i; j++)
        if (desc ? (e[j] < e[j+1]) : (e[j] > e[j+1])) begin
          t = e[j]; e[j] = e[j+1]; e[j+1] = t;
        end
    r = '0;
    for (int i = 0; i < n; i++) r[i*4 +: 4] = e[i];
    return r;
  endfunction

  // One isolated vector: latency, data, mode bit and single-cycle outValid.
  task automatic run_vec(input vec_t v, input int idx);
    int edges;
    int st;
    st   = (v.n == 8) ? 6 : 3;
    sel8 = (v.n == 8);
    iv4 = (v.n == 4); id4 = v.data[15:0]; idesc4 = v.desc;
    iv8 = (v.n == 8); id8 = v.data;       idesc8 = v.desc;
    @(posedge clk); #1;
    iv4 = 1'b0; iv8 = 1'b0;
    edges = 1;
    while (!o_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk($sformatf("vec%0d_latency", idx), edges, st);
    chk($sformatf("vec%0d_data", idx), o_data, v.exp);
    chk($sformatf("vec%0d_desc", idx), o_desc, v.desc);
    @(posedge clk); #1;
    chk($sformatf("vec%0d_pulse", idx), o_valid, 1'b0);
  endtask

  logic [16:0] q[$];
  logic [16:0] e17;
  logic [31:0] r32;
  logic [15:0] d16;
  logic        ds;
  logic [15:0] held;
  logic        held_desc;
  logic        stalled;
  logic        acc;
  logic [15:0] bp_data[5];
  int          got, first, last, idx, extra;

  initial begin
    errors = 0; checks = 0;
    rstN = 1'b0; sel8 = 1'b0;
    iv4 = 0; id4 = '0; idesc4 = 0; or4 = 1;
    iv8 = 0; id8 = '0; idesc8 = 0; or8 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov4", ov4, 1'b0);
    chk("rst_od4", od4, 16'h0);
    chk("rst_odesc4", odesc4, 1'b0);
    chk("rst_ir4", ir4, 1'b1);
    chk("rst_ov8", ov8, 1'b0);
    chk("rst_od8", od8, 32'h0);
    chk("rst_ir8", ir8, 1'b1);
    rstN = 1'b1;

    tbl.push_back('{4, pk4(9, 3, 12, 3),  1'b0, pk4(3, 3, 9, 12)});
    tbl.push_back('{4, pk4(9, 3, 12, 3),  1'b1, pk4(12, 9, 3, 3)});
    tbl.push_back('{4, pk4(1, 2, 3, 4),   1'b1, pk4(4, 3, 2, 1)});
    tbl.push_back('{4, pk4(0, 15, 7, 8),  1'b0, pk4(0, 7, 8, 15)});
    tbl.push_back('{4, pk4(15, 15, 0, 1), 1'b1, pk4(15, 15, 1, 0)});
    tbl.push_back('{8, pk8(5, 5, 5, 5, 5, 5, 5, 5),         1'b0, pk8(5, 5, 5, 5, 5, 5, 5, 5)});
    tbl.push_back('{8, pk8(0, 1, 2, 3, 4, 5, 6, 7),         1'b0, pk8(0, 1, 2, 3, 4, 5, 6, 7)});
    tbl.push_back('{8, pk8(0, 1, 2, 3, 4, 5, 6, 7),         1'b1, pk8(7, 6, 5, 4, 3, 2, 1, 0)});
    tbl.push_back('{8, pk8(7, 6, 5, 4, 3, 2, 1, 0),         1'b0, pk8(0, 1, 2, 3, 4, 5, 6, 7)});
    tbl.push_back('{8, pk8(15, 0, 15, 0, 15, 0, 15, 0),     1'b0, pk8(0, 0, 0, 0, 15, 15, 15, 15)});
    tbl.push_back('{8, pk8(15, 0, 15, 0, 15, 0, 15, 0),     1'b1, pk8(15, 15, 15, 15, 0, 0, 0, 0)});
    tbl.push_back('{8, pk8(3, 14, 1, 9, 2, 6, 5, 3),        1'b0, pk8(1, 2, 3, 3, 5, 6, 9, 14)});

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Back-to-back: 8 random vectors on consecutive cycles into the N=4 pipe.
    sel8 = 1'b0; or4 = 1'b1;
    q.delete(); got = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        d16 = 16'($urandom); ds = 1'($urandom_range(0, 1));
        iv4 = 1'b1; id4 = d16; idesc4 = ds;
      end else begin
        iv4 = 1'b0;
      end
      @(posedge clk);
      if (c < 8) begin
        r32 = ref_sort({16'h0, d16}, 4, ds);
        q.push_back({ds, r32[15:0]});
      end
      #1;
      if (ov4) begin
        if (q.size() > 0) e17 = q.pop_front();
        else e17 = 17'h1ffff;
        chk($sformatf("b2b%0d_data", got), od4, e17[15:0]);
        chk($sformatf("b2b%0d_desc", got), odesc4, e17[16]);
        got++;
        if (first < 0) first = c;
        last = c;
      end
    end
    chk("b2b_count", got, 8);
    chk("b2b_first", first, 2);
    chk("b2b_span", last - first, 7);

    // Backpressure: outReady low for cycles 4..7 while streaming 5 vectors.
    bp_data[0] = pk4(9, 3, 12, 3); bp_data[1] = pk4(1, 0, 14, 7);
    bp_data[2] = pk4(6, 6, 2, 11); bp_data[3] = pk4(15, 4, 8, 0);
    bp_data[4] = pk4(2, 13, 5, 10);
    q.delete(); got = 0; idx = 0; stalled = 1'b0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      or4 = !(c >= 4 && c <= 7);
      if (idx < 5) begin
        iv4 = 1'b1; id4 = bp_data[idx]; idesc4 = (idx % 2) == 1;
      end else begin
        iv4 = 1'b0;
      end
      #1;
      chk($sformatf("bp%0d_inready", c), ir4, !(ov4 && !or4));
      stalled = ov4 && !or4;
      held = od4; held_desc = odesc4;
      if (ov4 && or4) begin
        if (q.size() > 0) e17 = q.pop_front();
        else e17 = 17'h1ffff;
        chk($sformatf("bp_out%0d_data", got), od4, e17[15:0]);
        chk($sformatf("bp_out%0d_desc", got), odesc4, e17[16]);
        got++;
      end
      acc = iv4 && ir4;
      @(posedge clk);
      if (acc) begin
        r32 = ref_sort({16'h0, id4}, 4, idesc4);
        q.push_back({idesc4, r32[15:0]});
        idx++;
      end
      #1;
      if (stalled) begin
        chk($sformatf("bp%0d_hold_valid", c), ov4, 1'b1);
        chk($sformatf("bp%0d_hold_data", c), od4, held);
        chk($sformatf("bp%0d_hold_desc", c), odesc4, held_desc);
      end
    end
    iv4 = 1'b0; or4 = 1'b1;
    chk("bp_accepted", idx, 5);
    chk("bp_delivered", got, 5);
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ov4) extra++;
    end
    chk("bp_no_dup", extra, 0);
    chk("bp_queue_empty", q.size(), 0);

    // Reset mid-stream: v0 at the output, two more in flight.
    iv4 = 1'b1; id4 = pk4(9, 3, 12, 3); idesc4 = 1'b1;
    @(posedge clk); #1;
    id4 = pk4(1, 2, 3, 4); idesc4 = 1'b0;
    @(posedge clk); #1;
    id4 = pk4(8, 8, 1, 4); idesc4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    chk("rst_mid_pre_valid", ov4, 1'b1);
    chk("rst_mid_pre_data", od4, pk4(12, 9, 3, 3));
    rstN = 1'b0;
    #1;
    chk("rst_mid_ov4", ov4, 1'b0);
    chk("rst_mid_od4", od4, 16'h0);
    chk("rst_mid_odesc4", odesc4, 1'b0);
    chk("rst_mid_ir4", ir4, 1'b1);
    @(posedge clk); #1;
    rstN = 1'b1;
    iv4 = 1'b1; id4 = pk4(7, 0, 13, 2); idesc4 = 1'b0;
    @(posedge clk); #1;
    iv4 = 1'b0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (ov4) begin
        chk("rst_mid_new_data", od4, pk4(0, 2, 7, 13));
        chk("rst_mid_new_desc", odesc4, 1'b0);
        got++;
      end
      @(posedge clk); #1;
    end
    chk("rst_mid_only_new", got, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
